// File: rtl/multi_chan_data_sync.sv
// Multi-channel enable synchronizer with per-channel capture, a one-deep pending slot,
// and a round-robin merge of all channels into a single valid/ready event stream.
module multi_chan_data_sync #(
    parameter int unsigned NUM_STAGES = 2,
    parameter int unsigned BUS_WIDTH  = 8,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned EN_MODE    = 0,
    localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
    input  logic [NUM_CH-1:0]           bus_enable,
    output logic [NUM_CH*BUS_WIDTH-1:0] sync_bus,
    output logic [NUM_CH-1:0]           enable_pulse,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [CH_W-1:0]             evt_ch,
    output logic [BUS_WIDTH-1:0]        evt_data,
    output logic [NUM_CH-1:0]           overflow,
    input  logic [NUM_CH-1:0]           ovf_clr
);

    logic [NUM_STAGES-1:0]       r_sync [NUM_CH];
    logic [NUM_CH-1:0]           r_hist;
    logic [NUM_CH-1:0]           w_last;
    logic [NUM_CH-1:0]           w_det;
    logic [NUM_CH*BUS_WIDTH-1:0] r_sync_bus;
    logic [NUM_CH-1:0]           r_pulse;
    logic [NUM_CH-1:0]           r_pending;
    logic [BUS_WIDTH-1:0]        r_slot [NUM_CH];
    logic [NUM_CH-1:0]           r_overflow;
    logic [CH_W-1:0]             r_rr_ptr;
    logic [CH_W-1:0]             w_sel;
    logic                        w_found;
    logic                        w_accept;
    logic [NUM_CH-1:0]           w_acc_ch;

    // Only the enable is synchronized; data is sampled once the enable has settled.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_sync[i] <= '0;
            end
            r_hist <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_sync[i] <= {r_sync[i][NUM_STAGES-2:0], bus_enable[i]};
                r_hist[i] <= r_sync[i][NUM_STAGES-1];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_last[i] = r_sync[i][NUM_STAGES-1];
        end
        if (EN_MODE == 0) begin
            w_det = w_last & ~r_hist;
        end else begin
            w_det = w_last ^ r_hist;
        end
    end

    // First pending channel at or after the round-robin pointer.
    always_comb begin
        int unsigned idx;
        w_sel   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(r_rr_ptr) + k) % NUM_CH;
            if (!w_found && r_pending[idx]) begin
                w_found = 1'b1;
                w_sel   = CH_W'(idx);
            end
        end
    end

    always_comb begin
        evt_valid = |r_pending;
        evt_ch    = w_sel;
        evt_data  = r_slot[w_sel];
        w_accept  = evt_valid && evt_ready;
        for (int i = 0; i < NUM_CH; i++) begin
            w_acc_ch[i] = w_accept && (w_sel == CH_W'(i));
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync_bus <= '0;
            r_pulse    <= '0;
            r_pending  <= '0;
            r_overflow <= '0;
            r_rr_ptr   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            r_pulse <= w_det;
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_det[i]) begin
                    r_sync_bus[i*BUS_WIDTH +: BUS_WIDTH] <= unsync_bus[i*BUS_WIDTH +: BUS_WIDTH];
                    r_slot[i]    <= unsync_bus[i*BUS_WIDTH +: BUS_WIDTH];
                    r_pending[i] <= 1'b1;
                end else if (w_acc_ch[i]) begin
                    r_pending[i] <= 1'b0;
                end
                // A capture landing on an unaccepted slot loses the older word.
                if (w_det[i] && r_pending[i] && !w_acc_ch[i]) begin
                    r_overflow[i] <= 1'b1;
                end else if (ovf_clr[i]) begin
                    r_overflow[i] <= 1'b0;
                end
            end
            if (w_accept) begin
                r_rr_ptr <= (w_sel == CH_W'(NUM_CH - 1)) ? '0 : w_sel + 1'b1;
            end
        end
    end

    assign sync_bus     = r_sync_bus;
    assign enable_pulse = r_pulse;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_multi_chan_data_sync.sv
// Scoreboard bench for multi_chan_data_sync: level-mode instance for the merged stream and
// overflow paths, toggle-mode instance for edge detection.
module tb_multi_chan_data_sync;

    logic        clk;
    logic        rst;
    logic [31:0] unsync0, sync_bus0, unsync1, sync_bus1;
    logic [3:0]  en0, pulse0, ovf0, clr0, en1, pulse1, ovf1;
    logic        evt_valid0, evt_ready0, evt_valid1;
    logic [1:0]  evt_ch0, evt_ch1;
    logic [7:0]  evt_data0, evt_data1;

    int          n_vec;
    int          n_err;
    logic [31:0] sb_q [$];

    multi_chan_data_sync #(.NUM_STAGES(2), .BUS_WIDTH(8), .NUM_CH(4), .EN_MODE(0)) u_dut0 (
        .CLK(clk), .RST(rst), .unsync_bus(unsync0), .bus_enable(en0), .sync_bus(sync_bus0),
        .enable_pulse(pulse0), .evt_valid(evt_valid0), .evt_ready(evt_ready0),
        .evt_ch(evt_ch0), .evt_data(evt_data0), .overflow(ovf0), .ovf_clr(clr0)
    );

    multi_chan_data_sync #(.NUM_STAGES(2), .BUS_WIDTH(8), .NUM_CH(4), .EN_MODE(1)) u_dut1 (
        .CLK(clk), .RST(rst), .unsync_bus(unsync1), .bus_enable(en1), .sync_bus(sync_bus1),
        .enable_pulse(pulse1), .evt_valid(evt_valid1), .evt_ready(1'b1),
        .evt_ch(evt_ch1), .evt_data(evt_data1), .overflow(ovf1), .ovf_clr(4'b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [7:0] d, input logic e);
        unsync0[ch*8 +: 8] = d;
        en0[ch] = e;
    endtask

    function automatic logic [31:0] evt_obs();
        return 32'({evt_ch0, evt_data0});
    endfunction

    // Pops one expected event per cycle while accepting with ready held high.
    task automatic drain();
        logic [31:0] exp;
        evt_ready0 = 1'b1;
        while (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            check("drain_valid", 32'(evt_valid0), 32'h1);
            check("drain_evt", evt_obs(), exp);
            tick();
        end
        evt_ready0 = 1'b0;
        check("drain_idle", 32'(evt_valid0), 32'h0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        unsync0 = '0; en0 = '0; clr0 = '0; evt_ready0 = 1'b0;
        unsync1 = '0; en1 = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_valid", 32'(evt_valid0), 32'h0);
        check("rst_pulse", 32'(pulse0), 32'h0);
        check("rst_ovf", 32'(ovf0), 32'h0);
        check("rst_bus", sync_bus0, 32'h0);

        // Basic latency: rise sampled at E1, pulse after E3.
        set_ch(0, 8'h93, 1'b1);
        tick();
        tick();
        check("t1_early", 32'(pulse0), 32'h0);
        tick();
        check("t1_pulse", 32'(pulse0), 32'h1);
        check("t1_bus", 32'(sync_bus0[7:0]), 32'h93);
        check("t1_valid", 32'(evt_valid0), 32'h1);
        check("t1_evt", evt_obs(), 32'h093);
        tick();
        check("t1_once", 32'(pulse0), 32'h0);

        // Overwrite of an unaccepted slot.
        set_ch(0, 8'h93, 1'b0);
        repeat (3) tick();
        set_ch(0, 8'hBB, 1'b1);
        repeat (3) tick();
        check("t2_evt", evt_obs(), 32'h0BB);
        check("t2_ovf", 32'(ovf0), 32'h1);
        clr0 = 4'b0001;
        tick();
        clr0 = 4'b0000;
        check("t2_clr", 32'(ovf0), 32'h0);
        sb_q.push_back(32'h0BB);
        drain();

        // Three channels at once, served round-robin from ch1.
        set_ch(1, 8'hA1, 1'b1);
        set_ch(2, 8'hA2, 1'b1);
        set_ch(3, 8'hA3, 1'b1);
        repeat (3) tick();
        check("t3_pulse", 32'(pulse0), 32'hE);
        sb_q.push_back(32'h1A1);
        sb_q.push_back(32'h2A2);
        sb_q.push_back(32'h3A3);
        drain();
        check("t3_ovf", 32'(ovf0), 32'h0);

        // Capture on ch1 on the same edge ch1 is accepted.
        set_ch(1, 8'hA1, 1'b0);
        repeat (3) tick();
        set_ch(1, 8'h55, 1'b1);
        repeat (3) tick();
        set_ch(1, 8'h55, 1'b0);
        repeat (3) tick();
        set_ch(1, 8'h66, 1'b1);
        tick();
        tick();
        check("t6_before", evt_obs(), 32'h155);
        evt_ready0 = 1'b1;
        tick();
        evt_ready0 = 1'b0;
        check("t6_valid", 32'(evt_valid0), 32'h1);
        check("t6_evt", evt_obs(), 32'h166);
        check("t6_ovf", 32'(ovf0[1]), 32'h0);
        check("t6_pulse", 32'(pulse0), 32'h2);
        sb_q.push_back(32'h166);
        drain();

        // Reset with ch0 pending and ch2 mid-chain.
        set_ch(0, 8'hBB, 1'b0);
        repeat (3) tick();
        set_ch(0, 8'h77, 1'b1);
        repeat (3) tick();
        check("t5_pend", 32'(evt_valid0), 32'h1);
        set_ch(2, 8'hA2, 1'b0);
        repeat (3) tick();
        set_ch(2, 8'h88, 1'b1);
        tick();
        rst = 1'b1;
        en0 = '0;
        tick();
        rst = 1'b0;
        sb_q.delete();
        check("t5_bus", sync_bus0, 32'h0);
        check("t5_ovf", 32'(ovf0), 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("t5_pulse", 32'(pulse0), 32'h0);
            check("t5_valid", 32'(evt_valid0), 32'h0);
            tick();
        end

        // Toggle mode: both edges produce a pulse, held levels do not.
        unsync1[7:0] = 8'h11;
        en1[0] = 1'b1;
        tick();
        tick();
        check("t4_early", 32'(pulse1), 32'h0);
        tick();
        check("t4_rise", 32'(pulse1), 32'h1);
        check("t4_bus1", 32'(sync_bus1[7:0]), 32'h11);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_hold_hi", 32'(pulse1), 32'h0);
        end
        unsync1[7:0] = 8'h22;
        en1[0] = 1'b0;
        repeat (3) tick();
        check("t4_fall", 32'(pulse1), 32'h1);
        check("t4_bus2", 32'(sync_bus1[7:0]), 32'h22);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_hold_lo", 32'(pulse1), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
